// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready flow control,
// load-use hazard detection, flush and bubble counting.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef INS_NOP
`define INS_NOP 32'h0000_0013
`endif

module id_ex_pipe (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid_i,
  input  logic [`CPU_WIDTH-1:0]      ins_i,
  input  logic [`CPU_WIDTH-1:0]      ins_adder_i,
  input  logic [`REG_ADDR_WIDTH-1:0] rs1_adder_i,
  input  logic [`REG_ADDR_WIDTH-1:0] rs2_adder_i,
  input  logic [`CPU_WIDTH-1:0]      reg1_rd_data_i,
  input  logic [`CPU_WIDTH-1:0]      reg2_rd_data_i,
  input  logic [`CPU_WIDTH-1:0]      csr_rd_data_i,
  input  logic [`REG_ADDR_WIDTH-1:0] rd_adder_i,
  input  logic                       reg_wr_en_i,
  input  logic                       csr_wr_en_i,
  input  logic [`CSR_ADDR_WIDTH-1:0] csr_wr_adder_i,
  input  logic                       mem_rd_en_i,
  input  logic                       flush_i,
  input  logic                       ex_ready_i,
  output logic                       id_ready_o,
  output logic                       ex_valid_o,
  output logic [`CPU_WIDTH-1:0]      ins_o,
  output logic [`CPU_WIDTH-1:0]      ins_adder_o,
  output logic [`CPU_WIDTH-1:0]      reg1_data_o,
  output logic [`CPU_WIDTH-1:0]      reg2_data_o,
  output logic [`CPU_WIDTH-1:0]      csr_data_o,
  output logic [`REG_ADDR_WIDTH-1:0] rd_adder_o,
  output logic                       reg_wr_en_o,
  output logic                       csr_wr_en_o,
  output logic [`CSR_ADDR_WIDTH-1:0] csr_wr_adder_o,
  output logic                       mem_rd_en_o,
  output logic                       load_use_stall_o,
  output logic [31:0]                bubble_cnt_o
);

  typedef struct packed {
    logic                       valid;
    logic [`CPU_WIDTH-1:0]      ins;
    logic [`CPU_WIDTH-1:0]      pc;
    logic [`CPU_WIDTH-1:0]      r1;
    logic [`CPU_WIDTH-1:0]      r2;
    logic [`CPU_WIDTH-1:0]      csr;
    logic [`REG_ADDR_WIDTH-1:0] rd;
    logic                       reg_wr;
    logic                       csr_wr;
    logic [`CSR_ADDR_WIDTH-1:0] csr_adr;
    logic                       mem_rd;
  } id_ex_t;

  id_ex_t      q, d, cap, bub;
  logic [31:0] cnt_q, cnt_d;
  logic        src_hit, hazard, adv, hz_bubble;

  assign src_hit = (rs1_adder_i == q.rd)
                 | (rs2_adder_i == q.rd);

  assign hazard = id_valid_i & q.valid & q.mem_rd
                & q.reg_wr & (q.rd != '0) & src_hit;

  assign adv        = ~q.valid | ex_ready_i;
  assign hz_bubble  = ~flush_i & adv & hazard;
  assign id_ready_o = adv & ~hazard & ~flush_i;

  always_comb begin
    cap = '{
      valid:   1'b1,
      ins:     ins_i,
      pc:      ins_adder_i,
      r1:      reg1_rd_data_i,
      r2:      reg2_rd_data_i,
      csr:     csr_rd_data_i,
      rd:      rd_adder_i,
      reg_wr:  reg_wr_en_i,
      csr_wr:  csr_wr_en_i,
      csr_adr: csr_wr_adder_i,
      mem_rd:  mem_rd_en_i
    };
    // bubble keeps the data lanes, only kills valid and enables
    bub        = cap;
    bub.valid  = 1'b0;
    bub.ins    = `INS_NOP;
    bub.reg_wr = 1'b0;
    bub.csr_wr = 1'b0;
    bub.mem_rd = 1'b0;
  end

  always_comb begin
    d     = q;
    cnt_d = cnt_q;
    if (flush_i) begin
      d = bub;
    end else if (adv) begin
      d = (id_valid_i & ~hazard) ? cap : bub;
    end
    if (hz_bubble && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '{ins: `INS_NOP, default: '0};
      cnt_q <= '0;
    end else begin
      q     <= d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o       = q.valid;
  assign ins_o            = q.ins;
  assign ins_adder_o      = q.pc;
  assign reg1_data_o      = q.r1;
  assign reg2_data_o      = q.r2;
  assign csr_data_o       = q.csr;
  assign rd_adder_o       = q.rd;
  assign reg_wr_en_o      = q.reg_wr;
  assign csr_wr_en_o      = q.csr_wr;
  assign csr_wr_adder_o   = q.csr_adr;
  assign mem_rd_en_o      = q.mem_rd;
  assign load_use_stall_o = hazard;
  assign bubble_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table for the
// reset/flow/load-use/backpressure/flush/x0 cases, then random.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  logic [31:0] ins_i, ins_adder_i;
  logic [4:0]  rs1_adder_i, rs2_adder_i, rd_adder_i;
  logic [31:0] reg1_rd_data_i, reg2_rd_data_i, csr_rd_data_i;
  logic        reg_wr_en_i, csr_wr_en_i, mem_rd_en_i;
  logic [11:0] csr_wr_adder_i;
  logic        flush_i, ex_ready_i;
  logic        id_ready_o, ex_valid_o;
  logic [31:0] ins_o, ins_adder_o, reg1_data_o;
  logic [31:0] reg2_data_o, csr_data_o;
  logic [4:0]  rd_adder_o;
  logic        reg_wr_en_o, csr_wr_en_o, mem_rd_en_o;
  logic [11:0] csr_wr_adder_o;
  logic        load_use_stall_o;
  logic [31:0] bubble_cnt_o;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .ins_i(ins_i),
    .ins_adder_i(ins_adder_i),
    .rs1_adder_i(rs1_adder_i), .rs2_adder_i(rs2_adder_i),
    .reg1_rd_data_i(reg1_rd_data_i),
    .reg2_rd_data_i(reg2_rd_data_i),
    .csr_rd_data_i(csr_rd_data_i),
    .rd_adder_i(rd_adder_i), .reg_wr_en_i(reg_wr_en_i),
    .csr_wr_en_i(csr_wr_en_i),
    .csr_wr_adder_i(csr_wr_adder_i),
    .mem_rd_en_i(mem_rd_en_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .id_ready_o(id_ready_o), .ex_valid_o(ex_valid_o),
    .ins_o(ins_o), .ins_adder_o(ins_adder_o),
    .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o),
    .csr_data_o(csr_data_o), .rd_adder_o(rd_adder_o),
    .reg_wr_en_o(reg_wr_en_o), .csr_wr_en_o(csr_wr_en_o),
    .csr_wr_adder_o(csr_wr_adder_o),
    .mem_rd_en_o(mem_rd_en_o),
    .load_use_stall_o(load_use_stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ins;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, mrd, fl, rdy;
    logic        cc;
    logic        e_rdy, e_stall, e_v;
    logic [31:0] e_ins, e_b;
  } vec_t;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] LW5   = 32'h0000_2283;
  localparam logic [31:0] ADD6  = 32'h0012_8333;
  localparam logic [31:0] LW0   = 32'h0000_2003;
  localparam logic [31:0] ADD7  = 32'h0000_03b3;

  vec_t tv[16];

  function automatic vec_t mk(
    logic rst, logic iv, logic [31:0] ins,
    logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
    logic wr, logic mrd, logic fl, logic rdy, logic cc,
    logic e_rdy, logic e_stall, logic e_v,
    logic [31:0] e_ins, logic [31:0] e_b);
    vec_t v;
    v = '{rst, iv, ins, rs1, rs2, rd, wr, mrd, fl, rdy,
          cc, e_rdy, e_stall, e_v, e_ins, e_b};
    return v;
  endfunction

  // reference slot: what EX should hold, by the stage rules
  typedef struct {
    logic        v;
    logic [31:0] ins, pc, r1, r2, csr;
    logic [4:0]  rd;
    logic        wr, cwr, mrd;
    logic [11:0] cadr;
  } slot_t;

  slot_t       m;
  logic [31:0] m_b;

  task automatic drive_ctl(input logic [4:0] rs1,
                           input logic [4:0] rs2,
                           input logic [4:0] rd);
    rs1_adder_i = rs1;
    rs2_adder_i = rs2;
    rd_adder_i  = rd;
  endtask

  initial begin
    rst_n = 1'b0; id_valid_i = 1'b0; ins_i = NOP;
    ins_adder_i = '0; reg1_rd_data_i = '0;
    reg2_rd_data_i = '0; csr_rd_data_i = '0;
    drive_ctl(5'd0, 5'd0, 5'd0);
    reg_wr_en_i = 1'b0; csr_wr_en_i = 1'b0;
    csr_wr_adder_i = '0; mem_rd_en_i = 1'b0;
    flush_i = 1'b0; ex_ready_i = 1'b1;

    // rst iv ins rs1 rs2 rd wr mrd fl rdy | cc rdy stl v ins b
    tv[0]  = mk(0,1,ADDI1,0,0,1,1,0,0,1, 0,0,0,0,NOP,0);
    tv[1]  = mk(0,1,ADDI1,0,0,1,1,0,0,1, 1,1,0,0,NOP,0);
    tv[2]  = mk(1,1,ADDI1,0,0,1,1,0,0,1, 1,1,0,1,ADDI1,0);
    tv[3]  = mk(1,1,ADDI2,0,0,2,1,0,0,1, 1,1,0,1,ADDI2,0);
    tv[4]  = mk(1,1,LW5,  0,0,5,1,1,0,1, 1,1,0,1,LW5,0);
    tv[5]  = mk(1,1,ADD6, 5,1,6,1,0,0,1, 1,0,1,0,NOP,1);
    tv[6]  = mk(1,1,ADD6, 5,1,6,1,0,0,1, 1,1,0,1,ADD6,1);
    tv[7]  = mk(1,1,ADDI1,0,0,1,1,0,0,0, 1,0,0,1,ADD6,1);
    tv[8]  = mk(1,1,ADDI1,0,0,1,1,0,0,0, 1,0,0,1,ADD6,1);
    tv[9]  = mk(1,1,ADDI1,0,0,1,1,0,0,0, 1,0,0,1,ADD6,1);
    tv[10] = mk(1,1,ADDI1,0,0,1,1,0,0,1, 1,1,0,1,ADDI1,1);
    tv[11] = mk(1,1,LW5,  0,0,5,1,1,0,1, 1,1,0,1,LW5,1);
    tv[12] = mk(1,1,ADD6, 5,1,6,1,0,1,1, 1,0,1,0,NOP,1);
    tv[13] = mk(1,1,LW0,  0,0,0,1,1,0,1, 1,1,0,1,LW0,1);
    tv[14] = mk(1,1,ADD7, 0,0,7,1,0,0,1, 1,1,0,1,ADD7,1);
    tv[15] = mk(1,0,NOP,  0,0,0,0,0,0,1, 1,1,0,0,NOP,1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_n = tv[i].rst; id_valid_i = tv[i].iv;
      ins_i = tv[i].ins; ins_adder_i = 32'h100 + 4 * i;
      reg1_rd_data_i = i; reg2_rd_data_i = 2 * i;
      drive_ctl(tv[i].rs1, tv[i].rs2, tv[i].rd);
      reg_wr_en_i = tv[i].wr; mem_rd_en_i = tv[i].mrd;
      flush_i = tv[i].fl; ex_ready_i = tv[i].rdy;
      #1;
      if (tv[i].cc) begin
        chk($sformatf("t%0d id_ready", i),
            {31'd0, id_ready_o}, {31'd0, tv[i].e_rdy});
        chk($sformatf("t%0d stall", i),
            {31'd0, load_use_stall_o}, {31'd0, tv[i].e_stall});
      end
      @(posedge clk); #1;
      chk($sformatf("t%0d ex_valid", i),
          {31'd0, ex_valid_o}, {31'd0, tv[i].e_v});
      chk($sformatf("t%0d ins", i), ins_o, tv[i].e_ins);
      chk($sformatf("t%0d bubbles", i), bubble_cnt_o, tv[i].e_b);
    end

    // random traffic against the reference slot
    m = '{v: 1'b0, ins: NOP, default: '0};
    m_b = '0;
    for (int i = 0; i < 3000; i++) begin
      logic hz, adv, rdy_e;
      @(negedge clk);
      rst_n = (i == 0) ? 1'b0 : ($urandom_range(99) >= 2);
      id_valid_i = ($urandom_range(9) < 8);
      ins_i = $urandom; ins_adder_i = $urandom;
      reg1_rd_data_i = $urandom; reg2_rd_data_i = $urandom;
      csr_rd_data_i = $urandom;
      drive_ctl(5'($urandom_range(3)), 5'($urandom_range(3)),
                5'($urandom_range(3)));
      reg_wr_en_i = ($urandom_range(3) != 0);
      csr_wr_en_i = $urandom_range(1);
      csr_wr_adder_i = 12'($urandom);
      mem_rd_en_i = $urandom_range(1);
      flush_i = ($urandom_range(9) == 0);
      ex_ready_i = ($urandom_range(9) < 7);
      #1;
      hz = id_valid_i && m.v && m.mrd && m.wr && m.rd != 0
           && (rs1_adder_i == m.rd || rs2_adder_i == m.rd);
      adv = !m.v || ex_ready_i;
      rdy_e = adv && !hz && !flush_i;
      if (i > 0) begin
        chk("rnd id_ready", {31'd0, id_ready_o}, {31'd0, rdy_e});
        chk("rnd stall", {31'd0, load_use_stall_o}, {31'd0, hz});
      end
      if (!rst_n) begin
        m = '{v: 1'b0, ins: NOP, default: '0};
        m_b = '0;
      end else if (flush_i || (adv && !(id_valid_i && !hz))) begin
        if (!flush_i && hz && m_b != 32'hFFFF_FFFF) m_b++;
        m.v = 0; m.ins = NOP; m.wr = 0; m.cwr = 0; m.mrd = 0;
      end else if (adv) begin
        m = '{v: 1'b1, ins: ins_i, pc: ins_adder_i,
              r1: reg1_rd_data_i, r2: reg2_rd_data_i,
              csr: csr_rd_data_i, rd: rd_adder_i,
              wr: reg_wr_en_i, cwr: csr_wr_en_i,
              mrd: mem_rd_en_i, cadr: csr_wr_adder_i};
      end
      @(posedge clk); #1;
      chk("rnd ex_valid", {31'd0, ex_valid_o}, {31'd0, m.v});
      chk("rnd ins", ins_o, m.ins);
      chk("rnd enables",
          {29'd0, reg_wr_en_o, csr_wr_en_o, mem_rd_en_o},
          {29'd0, m.wr, m.cwr, m.mrd});
      chk("rnd bubbles", bubble_cnt_o, m_b);
      if (m.v) begin
        chk("rnd pc", ins_adder_o, m.pc);
        chk("rnd reg1", reg1_data_o, m.r1);
        chk("rnd reg2", reg2_data_o, m.r2);
        chk("rnd csr", csr_data_o, m.csr);
        chk("rnd rd/csr_adr",
            {15'd0, rd_adder_o, csr_wr_adder_o},
            {15'd0, m.rd, m.cadr});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
